// File: rtl/pipe_pkg.sv
// Shared types and defaults for the fetch PC unit.
// Address type, fetch-state enum and reset/increment defaults.
package pipe_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

    localparam addr_t       PKG_RESET_PC = 32'h0000_0000;
    localparam int unsigned PKG_PC_INC   = 4;

endpackage

// File: rtl/pipe_pc_unit.sv
// Fetch program counter with branch redirect, stall-time target capture
// and misaligned-target drop. Macro PIPE_DELAY_SLOT_EN keeps delay slot.
module pipe_pc_unit
    import pipe_pkg::*;
#(
    parameter addr_t       RESET_PC = PKG_RESET_PC,
    parameter int unsigned PC_INC   = PKG_PC_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_flush,
    output logic        addr_err
);

    pc_state_e r_state;
    addr_t     r_pc;
    addr_t     r_pend;
    logic      r_addr_err;

    pc_state_e w_state_nxt;
    addr_t     w_pc_nxt;
    addr_t     w_pend_nxt;
    addr_t     w_pc_inc;
    logic      w_aerr_nxt;
    logic      w_redirect;
    logic      w_req;
    logic      w_misal;
    logic      w_acc;

    assign w_req    = br_valid & br_taken;
    assign w_misal  = |br_target[1:0];
    assign w_acc    = w_req & ~w_misal;
    assign w_pc_inc = r_pc + 32'(PC_INC);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_aerr_nxt  = 1'b0;
        w_redirect  = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_aerr_nxt = w_req & w_misal;
                if (!stall) begin
                    if (w_acc) begin
                        w_pc_nxt   = br_target;
                        w_redirect = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end else if (w_acc) begin
                    w_pend_nxt  = br_target;
                    w_state_nxt = ST_PEND;
                end
            end
            // oldest captured target wins; new requests are ignored here
            ST_PEND: begin
                if (!stall) begin
                    w_pc_nxt    = r_pend;
                    w_redirect  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend     <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_addr_err <= w_aerr_nxt;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_inc;
    assign addr_err = r_addr_err;

`ifdef PIPE_DELAY_SLOT_EN
    // delay-slot instruction executes, so nothing is killed
    logic w_unused_redirect;
    assign w_unused_redirect = w_redirect;
    assign if_flush          = 1'b0;
`else
    assign if_flush = w_redirect & ~rst;
`endif

endmodule

// File: tb/tb_pipe_pc_unit.sv
// Testbench for pipe_pc_unit: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pipe_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_flush;
    logic        addr_err;

    pipe_pc_unit dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .br_valid (br_valid),
        .br_taken (br_taken),
        .br_target(br_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .if_flush (if_flush),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pendq[$];
    logic        m_aerr;
    logic        exp_flush;
    logic [31:0] exp_p4;
    logic        obs_flush;
    logic [31:0] obs_p4;

    // One clock cycle: drive inputs, sample combinational outputs at the
    // falling edge, then advance the reference model across the rising edge.
    task automatic cycle(input logic r, input logic s, input logic bv,
                         input logic bt, input logic [31:0] tgt);
        logic req;
        logic aligned;
        rst       = r;
        stall     = s;
        br_valid  = bv;
        br_taken  = bt;
        br_target = tgt;
        req       = bv & bt;
        aligned   = (tgt % 4) == 0;
        exp_p4    = m_pc + 32'd4;
        if (r)
            exp_flush = 1'b0;
        else if (m_pendq.size() > 0)
            exp_flush = !s;
        else
            exp_flush = !s && req && aligned;
`ifdef PIPE_DELAY_SLOT_EN
        exp_flush = 1'b0;
`endif
        @(negedge clk);
        obs_flush = if_flush;
        obs_p4    = pc_plus4;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 32'h0;
            m_pendq.delete();
            m_aerr = 1'b0;
        end else begin
            m_aerr = (m_pendq.size() == 0) && req && !aligned;
            if (m_pendq.size() > 0) begin
                if (!s) m_pc = m_pendq.pop_front();
            end else if (req && aligned) begin
                if (s) m_pendq.push_back(tgt);
                else   m_pc = tgt;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 1, 32'h80);
        n_total++;
        if (obs_flush !== 1'b0)
            $display("FAIL reset_flush got=%b exp=0", obs_flush);
        else n_pass++;
        cycle(1, 0, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h0 || addr_err !== 1'b0)
            $display("FAIL reset_state pc=%h aerr=%b exp pc=0 aerr=0",
                     pc, addr_err);
        else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 0, 1, 32'h40);
            n_total++;
            if (pc !== 32'(i * 4) || obs_flush !== 1'b0)
                $display("FAIL seq[%0d] pc=%h flush=%b exp pc=%h flush=0",
                         i, pc, obs_flush, 32'(i * 4));
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        logic ef;
`ifdef PIPE_DELAY_SLOT_EN
        ef = 1'b0;
`else
        ef = 1'b1;
`endif
        cycle(0, 0, 1, 1, 32'h40);
        n_total++;
        if (obs_flush !== ef || pc !== 32'h40)
            $display("FAIL branch flush=%b pc=%h exp flush=%b pc=40",
                     obs_flush, pc, ef);
        else n_pass++;
        cycle(0, 0, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h44 || obs_flush !== 1'b0)
            $display("FAIL branch_after pc=%h flush=%b exp pc=44 flush=0",
                     pc, obs_flush);
        else n_pass++;
    endtask

    task automatic test_stall_pend();
        cycle(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h20)
            $display("FAIL pend_setup pc=%h exp=20", pc);
        else n_pass++;
        cycle(0, 1, 1, 1, 32'h100);
        n_total++;
        if (pc !== 32'h20 || obs_flush !== 1'b0)
            $display("FAIL pend_cap pc=%h flush=%b exp pc=20 flush=0",
                     pc, obs_flush);
        else n_pass++;
        cycle(0, 1, 1, 1, 32'h200);
        n_total++;
        if (pc !== 32'h20 || obs_flush !== 1'b0)
            $display("FAIL pend_second pc=%h flush=%b exp pc=20 flush=0",
                     pc, obs_flush);
        else n_pass++;
        cycle(0, 1, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h20 || obs_flush !== 1'b0)
            $display("FAIL pend_hold pc=%h flush=%b exp pc=20 flush=0",
                     pc, obs_flush);
        else n_pass++;
        cycle(0, 0, 1, 1, 32'h300);
        n_total++;
        if (pc !== 32'h100 || obs_flush !== exp_flush)
            $display("FAIL pend_release pc=%h flush=%b exp pc=100 flush=%b",
                     pc, obs_flush, exp_flush);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 0, 1, 1, 32'h42);
        n_total++;
        if (pc !== 32'hC || addr_err !== 1'b1 || obs_flush !== 1'b0)
            $display("FAIL misal pc=%h aerr=%b flush=%b exp pc=c aerr=1 flush=0",
                     pc, addr_err, obs_flush);
        else n_pass++;
        cycle(0, 0, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h10 || addr_err !== 1'b0)
            $display("FAIL misal_pulse pc=%h aerr=%b exp pc=10 aerr=0",
                     pc, addr_err);
        else n_pass++;
    endtask

    task automatic test_reset_in_pend();
        cycle(0, 1, 1, 1, 32'h80);
        cycle(1, 1, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h0 || obs_flush !== 1'b0)
            $display("FAIL rst_pend pc=%h flush=%b exp pc=0 flush=0",
                     pc, obs_flush);
        else n_pass++;
        cycle(0, 0, 0, 0, 32'h0);
        n_total++;
        if (pc !== 32'h4 || obs_flush !== 1'b0)
            $display("FAIL rst_pend_after pc=%h flush=%b exp pc=4 flush=0",
                     pc, obs_flush);
        else n_pass++;
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 32'h0);
        n_total++;
        if (obs_p4 !== 32'h0 || pc !== 32'h0 || addr_err !== 1'b0)
            $display("FAIL wrap p4=%h pc=%h aerr=%b exp p4=0 pc=0 aerr=0",
                     obs_p4, pc, addr_err);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        r, s, bv, bt;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            s   = ($urandom_range(0, 2) == 0);
            bv  = ($urandom_range(0, 2) == 0);
            bt  = $urandom_range(0, 1) == 1;
            tgt = $urandom & 32'hFFFF_FFFC;
            if (m_pendq.size() == 0 && $urandom_range(0, 5) == 0)
                tgt[1:0] = 2'($urandom_range(1, 3));
            cycle(r, s, bv, bt, tgt);
            n_total++;
            if (pc !== m_pc || addr_err !== m_aerr ||
                obs_flush !== exp_flush ||
                (!r && obs_p4 !== exp_p4))
                $display("FAIL rand[%0d] pc=%h/%h aerr=%b/%b flush=%b/%b p4=%h/%h",
                         i, pc, m_pc, addr_err, m_aerr, obs_flush, exp_flush,
                         obs_p4, exp_p4);
            else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        m_pc      = 32'h0;
        m_aerr    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_pend();
        test_misaligned();
        test_reset_in_pend();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
